fpu_dispatch: RTL and testbench

FPU_DISPATCH -- requirements
Module: fpu_dispatch

---
 rtl/fpu_dispatch.sv | 273 +++++++++++++++++++++++++++
 tb/tb_fpu_dispatch.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : fpu_dispatch
// Description : Command dispatcher for add/mul/div floating-point units.
//               Queues tagged commands, issues one operation at a time to the
//               selected unit, and returns results in acceptance order
//               through a first-word fall-through result FIFO.
//               Optional WAIT-state timeout: define FPU_DISPATCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_dispatch #(
    parameter int TAG_W       = 4,
    parameter int CMD_DEPTH   = 4,
    parameter int RES_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cmd,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [31:0]      in_din1,
    input  logic [31:0]      in_din2,
    output logic [2:0]       unit_dval,
    output logic [31:0]      unit_din1,
    output logic [31:0]      unit_din2,
    input  logic [2:0]       unit_rdy,
    input  logic [95:0]      unit_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    localparam int CMD_AW = $clog2(CMD_DEPTH);
    localparam int RES_AW = $clog2(RES_DEPTH);
    localparam int CMD_W  = 4 + TAG_W + 64;
    localparam int RES_W  = 33 + TAG_W;
    localparam logic [CMD_AW:0] CMD_FULL_CNT = (CMD_AW + 1)'(CMD_DEPTH);
    localparam logic [RES_AW:0] RES_FULL_CNT = (RES_AW + 1)'(RES_DEPTH);

    // Elaboration-time parameter sanity checks
    generate
        if ((CMD_DEPTH < 2) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0)) begin : g_chk_cmd_depth
            $error("fpu_dispatch: CMD_DEPTH must be a power of 2 and >= 2");
        end
        if ((RES_DEPTH < 2) || ((RES_DEPTH & (RES_DEPTH - 1)) != 0)) begin : g_chk_res_depth
            $error("fpu_dispatch: RES_DEPTH must be a power of 2 and >= 2");
        end
        if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 65535)) begin : g_chk_timeout
            $error("fpu_dispatch: TIMEOUT_CYC must be in 1..65535");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // ---------------- command FIFO ----------------
    logic [CMD_W-1:0]  cmd_mem [CMD_DEPTH];
    logic [CMD_AW-1:0] cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
    logic [CMD_AW:0]   cmd_cnt_q, cmd_cnt_d;
    logic              cmd_empty, cmd_full, cmd_push, cmd_pop;
    logic [3:0]        head_cmd;
    logic [TAG_W-1:0]  head_tag;
    logic [31:0]       head_d1, head_d2;
    logic [2:0]        head_unit;

    // ---------------- result FIFO ----------------
    logic [RES_W-1:0]  res_mem [RES_DEPTH];
    logic [RES_AW-1:0] res_wp_q, res_wp_d, res_rp_q, res_rp_d;
    logic [RES_AW:0]   res_cnt_q, res_cnt_d;
    logic              res_empty, res_full, res_push, res_pop;
    logic [RES_W-1:0]  res_wdata;
    logic [31:0]       res_head_result;
    logic [TAG_W-1:0]  res_head_tag;
    logic              res_head_err;

    // ---------------- operation state ----------------
    state_t            state_q, state_d;
    logic [2:0]        op_unit_q, op_unit_d;
    logic [TAG_W-1:0]  op_tag_q, op_tag_d;
    logic [31:0]       din1_q, din1_d, din2_q, din2_d;
    logic [2:0]        dval_q, dval_d;
    logic              wait_hit;
    logic [31:0]       sel_result;

`ifdef FPU_DISPATCH_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0]       tmo_q, tmo_d;
`endif

    assign cmd_empty = (cmd_cnt_q == '0);
    assign cmd_full  = (cmd_cnt_q == CMD_FULL_CNT);
    assign in_ready  = !cmd_full;
    assign cmd_push  = in_valid && in_ready;

    assign res_empty = (res_cnt_q == '0);
    assign res_full  = (res_cnt_q == RES_FULL_CNT);
    assign out_valid = !res_empty;
    assign res_pop   = out_valid && out_ready;

    assign {head_cmd, head_tag, head_d1, head_d2} = cmd_mem[cmd_rp_q];
    assign {res_head_result, res_head_tag, res_head_err} = res_mem[res_rp_q];

    // Head fields are masked so the outputs read zero while the FIFO is empty
    assign out_result = out_valid ? res_head_result : 32'h0;
    assign out_tag    = out_valid ? res_head_tag : '0;
    assign out_err    = out_valid ? res_head_err : 1'b0;

    assign unit_dval  = dval_q;
    assign unit_din1  = din1_q;
    assign unit_din2  = din2_q;
    assign busy       = (state_q != ST_IDLE) || !cmd_empty;

    // Only the completion bit of the unit actually in flight counts
    assign wait_hit   = |(unit_rdy & op_unit_q);
    assign sel_result = ({32{op_unit_q[0]}} & unit_result[31:0])
                      | ({32{op_unit_q[1]}} & unit_result[63:32])
                      | ({32{op_unit_q[2]}} & unit_result[95:64]);

    // Opcode decode to one-hot unit select; zero marks an illegal opcode
    always_comb begin
        head_unit = 3'b000;
        case (head_cmd)
            4'b0001: head_unit = 3'b001;
            4'b0010: head_unit = 3'b010;
            4'b0011: head_unit = 3'b100;
            default: head_unit = 3'b000;
        endcase
    end

    // FSM next-state, issue and result-push decisions
    always_comb begin
        state_d   = state_q;
        op_unit_d = op_unit_q;
        op_tag_d  = op_tag_q;
        din1_d    = din1_q;
        din2_d    = din2_q;
        dval_d    = 3'b000;
        cmd_pop   = 1'b0;
        res_push  = 1'b0;
        res_wdata = '0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Issue only when a result slot is guaranteed for the answer
                if (!cmd_empty && !res_full) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cmd_pop  = 1'b1;
                op_tag_d = head_tag;
                if (head_unit != 3'b000) begin
                    op_unit_d = head_unit;
                    dval_d    = head_unit;
                    din1_d    = head_d1;
                    din2_d    = head_d2;
                    state_d   = ST_WAIT;
`ifdef FPU_DISPATCH_TIMEOUT_EN
                    tmo_d     = 16'd0;
`endif
                end else begin
                    res_push  = 1'b1;
                    res_wdata = {32'h0, head_tag, 1'b1};
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_hit) begin
                    res_push  = 1'b1;
                    res_wdata = {sel_result, op_tag_q, 1'b0};
                    state_d   = ST_IDLE;
                end else begin
`ifdef FPU_DISPATCH_TIMEOUT_EN
                    if (tmo_q == TMO_LAST) begin
                        res_push  = 1'b1;
                        res_wdata = {32'h0, op_tag_q, 1'b1};
                        state_d   = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
`else
                    state_d = ST_WAIT;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        cmd_wp_d  = cmd_push ? cmd_wp_q + 1'b1 : cmd_wp_q;
        cmd_rp_d  = cmd_pop  ? cmd_rp_q + 1'b1 : cmd_rp_q;
        cmd_cnt_d = cmd_cnt_q;
        if (cmd_push && !cmd_pop) begin
            cmd_cnt_d = cmd_cnt_q + 1'b1;
        end else if (!cmd_push && cmd_pop) begin
            cmd_cnt_d = cmd_cnt_q - 1'b1;
        end
        res_wp_d  = res_push ? res_wp_q + 1'b1 : res_wp_q;
        res_rp_d  = res_pop  ? res_rp_q + 1'b1 : res_rp_q;
        res_cnt_d = res_cnt_q;
        if (res_push && !res_pop) begin
            res_cnt_d = res_cnt_q + 1'b1;
        end else if (!res_push && res_pop) begin
            res_cnt_d = res_cnt_q - 1'b1;
        end
    end

    // FIFO storage; contents need no reset because the counts gate visibility
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wp_q] <= {in_cmd, in_tag, in_din1, in_din2};
        end
        if (res_push) begin
            res_mem[res_wp_q] <= res_wdata;
        end
    end

    // State and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_unit_q <= 3'b000;
            op_tag_q  <= '0;
            din1_q    <= 32'h0;
            din2_q    <= 32'h0;
            dval_q    <= 3'b000;
            cmd_wp_q  <= '0;
            cmd_rp_q  <= '0;
            cmd_cnt_q <= '0;
            res_wp_q  <= '0;
            res_rp_q  <= '0;
            res_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            op_unit_q <= op_unit_d;
            op_tag_q  <= op_tag_d;
            din1_q    <= din1_d;
            din2_q    <= din2_d;
            dval_q    <= dval_d;
            cmd_wp_q  <= cmd_wp_d;
            cmd_rp_q  <= cmd_rp_d;
            cmd_cnt_q <= cmd_cnt_d;
            res_wp_q  <= res_wp_d;
            res_rp_q  <= res_rp_d;
            res_cnt_q <= res_cnt_d;
        end
    end

`ifdef FPU_DISPATCH_TIMEOUT_EN
    // WAIT-state cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= 16'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_dispatch
// Description : Scoreboard bench for fpu_dispatch. Stimulus pushes expected
//               results when a command is accepted; a monitor pops and
//               compares on every out_valid&out_ready; a unit model answers
//               issued operations after a planned delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_dispatch;

    localparam int TAG_W       = 4;
    localparam int CMD_DEPTH   = 4;
    localparam int RES_DEPTH   = 4;
    localparam int TIMEOUT_CYC = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_cmd = 4'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      in_din1 = 32'h0;
    logic [31:0]      in_din2 = 32'h0;
    logic [2:0]       unit_dval;
    logic [31:0]      unit_din1, unit_din2;
    logic [2:0]       unit_rdy = 3'b000;
    logic [95:0]      unit_result = 96'h0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic             busy;

    fpu_dispatch #(
        .TAG_W      (TAG_W),
        .CMD_DEPTH  (CMD_DEPTH),
        .RES_DEPTH  (RES_DEPTH),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .in_tag     (in_tag),
        .in_din1    (in_din1),
        .in_din2    (in_din2),
        .unit_dval  (unit_dval),
        .unit_din1  (unit_din1),
        .unit_din2  (unit_din2),
        .unit_rdy   (unit_rdy),
        .unit_result(unit_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] res;
        int          delay;
        bit          norsp;
    } plan_t;

    plan_t            plan_q[$];
    logic [32+TAG_W:0] exp_q[$];
    int               total = 0;
    int               bad = 0;
    int               dval_cnt = 0;
    bit               rnd_rdy_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Offer one command; record the expected outcome on acceptance
    task automatic send(input logic [3:0] cmd, input logic [TAG_W-1:0] tag,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] res, input int delay, input bit norsp);
        int    guard;
        plan_t p;
        guard    = 0;
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_tag   = tag;
        in_din1  = d1;
        in_din2  = d2;
        while (!in_ready && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            fail_bound("send_accept");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (cmd inside {4'd1, 4'd2, 4'd3}) begin
            p.cmd = cmd; p.d1 = d1; p.d2 = d2; p.res = res;
            p.delay = delay; p.norsp = norsp;
            plan_q.push_back(p);
            if (!norsp) begin
                exp_q.push_back({res, tag, 1'b0});
            end else begin
`ifdef FPU_DISPATCH_TIMEOUT_EN
                exp_q.push_back({32'h0, tag, 1'b1});
`endif
            end
        end else begin
            exp_q.push_back({32'h0, tag, 1'b1});
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || out_valid || exp_q.size() != 0) && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 3000) fail_bound("drain");
    endtask

    // Unit model: answers each issued op after its planned delay
    initial begin : responder
        plan_t      p;
        logic [2:0] want, noise;
        logic       was_valid;
        forever begin
            @(posedge clk); #1;
            if (!rst && unit_dval != 3'b000) begin
                dval_cnt++;
                if (plan_q.size() == 0) begin
                    fail_bound("unexpected_issue");
                end else begin
                    p    = plan_q.pop_front();
                    want = 3'b001 << (p.cmd - 4'd1);
                    chk("issue_unit", unit_dval, want);
                    chk("issue_din", {unit_din1, unit_din2}, {p.d1, p.d2});
                    if (!p.norsp) begin
                        for (int k = 1; k < p.delay; k++) begin
                            noise    = 3'($urandom) & ~want;
                            unit_rdy = noise;
                            @(posedge clk); #1;
                        end
                        noise       = 3'($urandom) & ~want;
                        unit_result = {$urandom, $urandom, $urandom};
                        case (p.cmd)
                            4'd1:    unit_result[31:0]  = p.res;
                            4'd2:    unit_result[63:32] = p.res;
                            default: unit_result[95:64] = p.res;
                        endcase
                        unit_rdy  = want | noise;
                        was_valid = out_valid;
                        @(posedge clk); #1;
                        unit_rdy = 3'b000;
                        if (!was_valid) chk("out_valid_rise", out_valid, 1'b1);
                    end
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        logic [32+TAG_W:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_bound("unexpected_out");
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", {out_result, out_tag, out_err}, e);
                end
            end
        end
    end

    // Random consumer back-pressure
    initial begin : ready_drv
        forever begin
            @(posedge clk); #1;
            if (rnd_rdy_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    logic [3:0] fill_cmd [CMD_DEPTH] = '{4'd3, 4'd1, 4'd2, 4'd1};

    initial begin : main
        int         base, g, v;
        logic       seen;
        logic [3:0] c;

        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst_dval", unit_dval, 3'b000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out", {out_result, out_tag, out_err}, '0);
        chk("rst_din", {unit_din1, unit_din2}, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_rst", in_ready, 1'b1);

        // Directed add with latency check
        out_ready = 1'b1;
        send(4'd1, 4'd5, 32'h3F800000, 32'h40000000, 32'h40400000, 4, 1'b0);
        chk("dval_N", unit_dval, 3'b000);
        @(posedge clk); #1;
        chk("dval_N1", unit_dval, 3'b000);
        @(posedge clk); #1;
        chk("dval_N2", unit_dval, 3'b001);
        wait_idle();

        // Illegal opcode
        base = dval_cnt;
        send(4'b0111, 4'd9, $urandom, $urandom, 32'h0, 1, 1'b0);
        wait_idle();
        chk("illegal_no_issue", dval_cnt - base, 0);

        // Command FIFO fill and result FIFO back-pressure
        out_ready = 1'b0;
        base = dval_cnt;
        send(4'd2, 4'd1, $urandom, $urandom, $urandom, 40, 1'b0);
        g = 0;
        while (dval_cnt == base && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (dval_cnt == base) fail_bound("first_issue");
        for (int i = 0; i < CMD_DEPTH; i++) begin
            chk("in_ready_fill", in_ready, 1'b1);
            send(fill_cmd[i], TAG_W'(i + 2), $urandom, $urandom, $urandom, 2, 1'b0);
        end
        chk("in_ready_full", in_ready, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        chk("res_full_hold", dval_cnt - base, RES_DEPTH);
        chk("res_full_out_valid", out_valid, 1'b1);
        chk("res_full_busy", busy, 1'b1);
        out_ready = 1'b1;
        wait_idle();
        chk("resume_after_pop", dval_cnt - base, CMD_DEPTH + 1);

`ifdef FPU_DISPATCH_TIMEOUT_EN
        // Timeout: no completion for the issued op
        send(4'd2, 4'd7, $urandom, $urandom, 32'h0, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("tmo_issue", unit_dval, 3'b010);
        g = 0;
        while (!out_valid && g < TIMEOUT_CYC + 4) begin
            @(posedge clk); #1;
            g++;
        end
        chk("tmo_latency", g, TIMEOUT_CYC);
        wait_idle();
        unit_rdy = 3'b111;
        @(posedge clk); #1;
        unit_rdy = 3'b000;
        seen = 1'b0;
        repeat (5) begin
            if (out_valid || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("tmo_stray_rdy", seen, 1'b0);
`endif

        // Reset during WAIT with queued commands
        send(4'd1, 4'd3, $urandom, $urandom, 32'h0, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        send(4'd2, 4'd4, $urandom, $urandom, 32'h0, 0, 1'b1);
        send(4'd3, 4'd6, $urandom, $urandom, 32'h0, 0, 1'b1);
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #2;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_din", {unit_din1, unit_din2}, 64'h0);
        plan_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        unit_result = {$urandom, $urandom, $urandom};
        unit_rdy    = 3'b111;
        @(posedge clk); #1;
        unit_rdy = 3'b000;
        seen = 1'b0;
        repeat (6) begin
            if (out_valid || busy || unit_dval != 3'b000) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("late_rdy_ignored", seen, 1'b0);
        chk("in_ready_after_midrst", in_ready, 1'b1);

        // Randomized traffic with random back-pressure
        rnd_rdy_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                v = $urandom_range(3, 15);
                c = (v == 3) ? 4'd0 : 4'(v);
            end else begin
                c = 4'($urandom_range(1, 3));
            end
            send(c, TAG_W'($urandom), $urandom, $urandom, $urandom,
                 $urandom_range(1, 6), 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
            end
        end
        rnd_rdy_en = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle();
        chk("final_plan_empty", plan_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
